// File: rtl/v850_pkg.sv
// Shared types and helpers for the V850 instruction fetch unit.
package v850_pkg;

    localparam int HW_W = 16;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_DROP
    } ifetch_state_e;

    // A halfword opens a 32-bit instruction when bits [10:9] are both set.
    function automatic logic is_len32(input logic [HW_W-1:0] hw);
        logic [HW_W-1:0] masked;
        masked = hw & 16'h0600;
        return masked == 16'h0600;
    endfunction

endpackage

// File: rtl/v850_hw_queue.sv
// Halfword FIFO accepting 0-2 pushes and 0-2 pops per cycle, exposing the two
// oldest entries so a 32-bit instruction can be taken in one go.
module v850_hw_queue
    import v850_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [1:0]      push_cnt,
    input  logic [HW_W-1:0] push_lo,
    input  logic [HW_W-1:0] push_hi,
    input  logic [1:0]      pop_cnt,
    output logic [PW-1:0]   count,
    output logic [HW_W-1:0] head0,
    output logic [HW_W-1:0] head1
);

    localparam int AW = PW - 1;

    logic [HW_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   wr_idx1;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   rd_idx1;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign wr_idx1 = wr_idx + AW'(1);
    assign rd_idx  = rd_ptr[AW-1:0];
    assign rd_idx1 = rd_idx + AW'(1);

    // The extra pointer bit distinguishes full from empty.
    assign count = wr_ptr - rd_ptr;
    assign head0 = mem[rd_idx];
    assign head1 = mem[rd_idx1];

    always_ff @(posedge clk) begin
        if (!flush && push_cnt != 2'd0) begin
            mem[wr_idx] <= push_lo;
        end
        if (!flush && push_cnt == 2'd2) begin
            mem[wr_idx1] <= push_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_cnt);
            rd_ptr <= rd_ptr + PW'(pop_cnt);
        end
    end

endmodule

// File: rtl/v850_fetch_unit.sv
// V850 fetch unit: word fetch FSM feeding a halfword queue, plus an output
// register that hands 16-/32-bit instructions to the decoder.
module v850_fetch_unit
    import v850_pkg::*;
#(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic        inst_len32,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    ifetch_state_e   state;
    ifetch_state_e   next_state;
    logic [31:0]     fetch_pc;
    logic [31:0]     dec_pc;
    logic [31:0]     redir_pc;
    logic            skip_lo;
    logic            issue;
    logic            accept;
    logic            load;
    logic            head_len32;
    logic            head_ok;
    logic [1:0]      push_cnt;
    logic [1:0]      pop_cnt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   free;
    logic [HW_W-1:0] head0;
    logic [HW_W-1:0] head1;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFE;
    assign free     = CW'(QDEPTH) - count;
    assign mem_req  = (state != IDLE);

    v850_hw_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_cnt (push_cnt),
        .push_lo  (skip_lo ? mem_rdata[31:16] : mem_rdata[15:0]),
        .push_hi  (mem_rdata[31:16]),
        .pop_cnt  (pop_cnt),
        .count    (count),
        .head0    (head0),
        .head1    (head1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests are only issued with room for a whole word, so a push never overflows.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_valid && free >= CW'(2)) begin
                    issue      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    accept     = !redirect_valid;
                    next_state = IDLE;
                end else if (redirect_valid) begin
                    next_state = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (mem_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        push_cnt = accept ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            skip_lo  <= RESET_PC[1];
            mem_addr <= 32'h0;
        end else begin
            if (issue) begin
                mem_addr <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= {redir_pc[31:2], 2'b00};
                skip_lo  <= redir_pc[1];
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                skip_lo  <= 1'b0;
            end
        end
    end

    // Instructions leave the queue as they enter the output register; dec_pc tracks the queue head.
    always_comb begin
        head_len32 = is_len32(head0);
        head_ok    = (count >= CW'(1)) && (!head_len32 || count >= CW'(2));
        load       = (!inst_valid || inst_ready) && head_ok && !redirect_valid;
        pop_cnt    = load ? (head_len32 ? 2'd2 : 2'd1) : 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_len32 <= 1'b0;
            inst_pc    <= 32'h0;
            dec_pc     <= RESET_PC;
        end else if (redirect_valid) begin
            inst_valid <= 1'b0;
            dec_pc     <= redir_pc;
        end else if (load) begin
            inst_valid <= 1'b1;
            inst       <= head_len32 ? {head1, head0} : {16'h0000, head0};
            inst_len32 <= head_len32;
            inst_pc    <= dec_pc;
            dec_pc     <= dec_pc + (head_len32 ? 32'd4 : 32'd2);
        end else if (inst_ready) begin
            inst_valid <= 1'b0;
        end
    end

endmodule
